// File: rtl/led_alert_scheduler.sv
// Shares one front-panel LED among prioritised alert sources: serves one
// requester at a time with a tick-paced blink burst, then an off-gap.
module led_alert_scheduler #(
  parameter int NUM_REQ   = 3,
  parameter int CNT_W     = 4,
  parameter int GAP_TICKS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     led_out,
  output logic                     busy
);
  // state | meaning
  // IDLE  | LED off, arbitrating on req (lowest index wins)
  // BLINK | serving grant, LED toggles on each tick
  // GAP   | LED off for GAP_TICKS ticks, requests not examined

  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, BLINK, GAP} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               led_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [NUM_REQ-1:0] win_oh;
  logic [CNT_W-1:0]   win_cnt;
  logic               served_req;
  logic               end_burst;

  always_comb begin
    win_oh  = '0;
    win_cnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_cnt   = req_count[i*CNT_W +: CNT_W];
      end
    end
  end

  assign served_req = |(req & grant);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant;
    done_d    = '0;
    led_d     = led_out;
    rem_d     = rem_q;
    gap_d     = gap_q;
    end_burst = 1'b0;
    case (state_q)
      IDLE: begin
        led_d = 1'b0;
        if (|req) begin
          grant_d = win_oh;
          rem_d   = win_cnt;
          state_d = BLINK;
        end
      end
      BLINK: begin
        // a withdrawn request wins over a coincident tick
        if (!served_req) begin
          grant_d   = '0;
          led_d     = 1'b0;
          end_burst = 1'b1;
        end else if (tick) begin
          led_d = ~led_out;
          if (led_out) begin
            if (rem_q == CNT_W'(1)) begin
              done_d    = grant;
              grant_d   = '0;
              end_burst = 1'b1;
            end else if (rem_q != '0) begin
              rem_d = rem_q - CNT_W'(1);
            end
          end
        end
      end
      GAP: begin
        led_d   = 1'b0;
        grant_d = '0;
        if (tick) begin
          gap_d = gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (end_burst) begin
      if (GAP_TICKS > 0) begin
        state_d = GAP;
        gap_d   = GAP_W'(GAP_TICKS);
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant   <= '0;
      done    <= '0;
      led_out <= 1'b0;
      rem_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      done    <= done_d;
      led_out <= led_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_led_alert_scheduler.sv
// Bench for led_alert_scheduler: a tick-counting burst model checked every
// cycle on two instances (gap of 2 ticks and no gap), plus directed checks.
module tb_led_alert_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [2:0]  reqa = '0, reqb = '0;
  logic [11:0] rca = '0, rcb = '0;
  logic [2:0]  grant_a, done_a, grant_b, done_b;
  logic        led_a, led_b, busy_a, busy_b;
  int          checks = 0;
  int          errors = 0;
  int          tick_cnt = 0;

  always #5 clk = ~clk;

  led_alert_scheduler u_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(reqa), .req_count(rca),
    .grant(grant_a), .done(done_a), .led_out(led_a), .busy(busy_a)
  );

  led_alert_scheduler #(.GAP_TICKS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(reqb), .req_count(rcb),
    .grant(grant_b), .done(done_b), .led_out(led_b), .busy(busy_b)
  );

  initial forever begin
    @(negedge clk);
    tick_cnt++;
    tick = (tick_cnt % 4 == 0);
  end

  // Model: a burst of N blinks is 2N ticks; LED is lit after an odd tick count.
  int         m_served[2] = '{-1, -1};
  int         m_ticks[2]  = '{0, 0};
  int         m_target[2] = '{0, 0};
  int         m_gap[2]    = '{0, 0};
  logic [2:0] m_done[2]   = '{3'b0, 3'b0};

  function automatic int gap_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic m_step(input int k, input logic [2:0] r, input logic [11:0] rc);
    m_done[k] = '0;
    if (m_served[k] >= 0) begin
      if (!r[m_served[k]]) begin
        m_served[k] = -1;
        m_gap[k]    = gap_of(k);
      end else if (tick) begin
        m_ticks[k]++;
        if (m_target[k] != 0 && m_ticks[k] == m_target[k]) begin
          m_done[k]   = 3'(1 << m_served[k]);
          m_served[k] = -1;
          m_gap[k]    = gap_of(k);
        end
      end
    end else if (m_gap[k] > 0) begin
      if (tick) m_gap[k]--;
    end else if (r != 0) begin
      for (int i = 2; i >= 0; i--) if (r[i]) m_served[k] = i;
      m_ticks[k]  = 0;
      m_target[k] = 2 * int'(rc[m_served[k]*4 +: 4]);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_served[k] = -1; m_ticks[k] = 0; m_gap[k] = 0; m_done[k] = '0;
      end
    end else begin
      m_step(0, reqa, rca);
      m_step(1, reqb, rcb);
    end
  end

  function automatic logic [2:0] e_grant(input int k);
    return (m_served[k] >= 0) ? 3'(1 << m_served[k]) : 3'b000;
  endfunction
  function automatic logic e_led(input int k);
    return (m_served[k] >= 0) && (m_ticks[k] % 2 == 1);
  endfunction
  function automatic logic e_busy(input int k);
    return (m_served[k] >= 0) || (m_gap[k] > 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("grant_a", 32'(grant_a), 32'(e_grant(0)));
    chk("done_a",  32'(done_a),  32'(m_done[0]));
    chk("led_a",   32'(led_a),   32'(e_led(0)));
    chk("busy_a",  32'(busy_a),  32'(e_busy(0)));
    chk("grant_b", 32'(grant_b), 32'(e_grant(1)));
    chk("done_b",  32'(done_b),  32'(m_done[1]));
    chk("led_b",   32'(led_b),   32'(e_led(1)));
    chk("busy_b",  32'(busy_b),  32'(e_busy(1)));
  end

  function automatic logic [2:0] g_of(input bit s); return s ? grant_b : grant_a; endfunction
  function automatic logic [2:0] d_of(input bit s); return s ? done_b : done_a; endfunction
  function automatic logic       l_of(input bit s); return s ? led_b : led_a; endfunction
  function automatic logic       b_of(input bit s); return s ? busy_b : busy_a; endfunction

  task automatic to_neg();
    @(negedge clk); #1;
  endtask

  // Call at negedge+1; returns at posedge+1 of the done edge (or on timeout).
  task automatic wait_done(input bit s, input int max_cyc, output int ticks,
                           output int rises, output logic [2:0] dval);
    logic prev, pt;
    logic [2:0] pg;
    bit ok;
    prev = l_of(s); ticks = 0; rises = 0; dval = '0; ok = 0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      pt = tick; pg = g_of(s);
      @(posedge clk); #1;
      if (pt && pg != 0) ticks++;
      if (l_of(s) && !prev) rises++;
      prev = l_of(s);
      if (d_of(s) != 0) begin dval = d_of(s); ok = 1; end
      else to_neg();
    end
    chk("done_within_budget", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input bit s, input int max_cyc, output int ticks);
    bit ok;
    logic pt;
    ticks = 0; ok = 0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      pt = tick;
      @(posedge clk); #1;
      if (pt) ticks++;
      if (!b_of(s)) ok = 1;
      to_neg();
    end
    chk("idle_within_budget", 32'(ok), 32'd1);
  endtask

  task automatic wait_led(input bit s, input int max_cyc);
    bit ok;
    ok = 0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      @(posedge clk); #1;
      if (l_of(s)) ok = 1;
      to_neg();
    end
    chk("led_within_budget", 32'(ok), 32'd1);
  endtask

  task automatic wait_grant(input bit s, input int max_cyc);
    bit ok;
    ok = 0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      @(posedge clk); #1;
      if (g_of(s) != 0) ok = 1;
      else to_neg();
    end
    chk("grant_within_budget", 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tk, rs, tg, dn;
    logic [2:0] dv;
    logic pt, pl;

    // reset with all requests and ticks running
    reqa = 3'b111;
    repeat (6) to_neg();
    chk("rst_grant", 32'(grant_a), 32'd0);
    chk("rst_led",   32'(led_a),   32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("grant_after_reset", 32'(grant_a), 32'b001);
    to_neg(); reqa = 3'b000;
    wait_idle(0, 100, tk);

    // single burst of 3 on source 1
    rca = {4'd0, 4'd3, 4'd0}; reqa = 3'b010;
    wait_done(0, 400, tk, rs, dv);
    chk("burst_done_val", 32'(dv), 32'b010);
    chk("burst_ticks",    32'(tk), 32'd6);
    chk("burst_rises",    32'(rs), 32'd3);
    to_neg(); reqa = 3'b000;
    wait_idle(0, 100, tk);
    chk("gap_ticks", 32'(tk), 32'd2);

    // priority without preemption
    rca = {4'd2, 4'd0, 4'd1}; reqa = 3'b100;
    wait_led(0, 100);
    reqa = 3'b101;
    wait_done(0, 400, tk, rs, dv);
    chk("prio_done_val", 32'(dv), 32'b100);
    chk("prio_blinks",   32'(rs + 1), 32'd2);
    to_neg(); reqa = 3'b001;
    wait_grant(0, 100);
    chk("prio_next_grant", 32'(grant_a), 32'b001);
    to_neg();
    wait_done(0, 400, tk, rs, dv);
    chk("prio2_done_val", 32'(dv), 32'b001);
    to_neg(); reqa = 3'b000;
    wait_idle(0, 100, tk);

    // continuous blinking, then abort while lit
    rca = '0; reqa = 3'b001;
    wait_led(0, 100);
    tg = 0; tk = 0; dn = 0;
    for (int c = 0; c < 200 && tk < 20; c++) begin
      pt = tick; pl = led_a;
      @(posedge clk); #1;
      if (pt) tk++;
      if (led_a != pl) tg++;
      if (done_a != 0) dn++;
      to_neg();
    end
    chk("cont_toggles", 32'(tg), 32'd20);
    chk("cont_no_done", 32'(dn), 32'd0);
    wait_led(0, 100);
    reqa = 3'b000;
    @(posedge clk); #1;
    chk("abort_led",   32'(led_a),   32'd0);
    chk("abort_grant", 32'(grant_a), 32'd0);
    chk("abort_busy",  32'(busy_a),  32'd1);
    chk("abort_done",  32'(done_a),  32'd0);
    to_neg();
    wait_idle(0, 100, tk);

    // maximum count, with a count change mid-burst
    rca = {8'd0, 4'd15}; reqa = 3'b001;
    fork
      wait_done(0, 600, tk, rs, dv);
      begin
        repeat (20) @(negedge clk);
        rca[3:0] = 4'd2;
      end
    join
    chk("max_done_val", 32'(dv), 32'b001);
    chk("max_rises",    32'(rs), 32'd15);
    chk("max_ticks",    32'(tk), 32'd30);
    to_neg(); reqa = 3'b000;
    wait_idle(0, 100, tk);

    // no gap: back-to-back service of a held request
    rcb = {8'd0, 4'd1}; reqb = 3'b001;
    wait_done(1, 100, tk, rs, dv);
    chk("nogap_done_val", 32'(dv), 32'b001);
    @(posedge clk); #1;
    chk("nogap_regrant", 32'(grant_b), 32'b001);
    to_neg(); reqb = 3'b000;
    repeat (3) to_neg();

    // asynchronous reset while lit
    rca = {4'd0, 4'd3, 4'd0}; reqa = 3'b010;
    wait_led(0, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_led",   32'(led_a),   32'd0);
    chk("async_grant", 32'(grant_a), 32'd0);
    chk("async_busy",  32'(busy_a),  32'd0);
    chk("async_done",  32'(done_a),  32'd0);
    reqa = 3'b000;
    repeat (3) to_neg();
    rst_n = 1'b1;
    repeat (3) to_neg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_alert_scheduler.md
# led_alert_scheduler

Shares the single front-panel LED among several alert sources in the timer design, such as timer expired, set mode and running. Each source requests a burst of N blinks, or continuous blinking. The block picks one requester by fixed priority, generates the blink waveform from a one-cycle tick strobe, reports completion, and then inserts an off-gap before it serves the next requester. It runs in the system clock domain and replaces direct toggling of the LED from a divided clock.

## Interface
- NUM_REQ, 3, number of requesters; index 0 has the highest priority.
- CNT_W, 4, width of each per-requester blink count.
- GAP_TICKS, 2, number of ticks the LED is held off after a burst before re-arbitration; 0 means no gap.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- tick  input  1  single-cycle strobe in the clk domain; one tick equals one LED half-period.
- req  input  NUM_REQ  level request per source; held high until the source sees done or withdraws.
- req_count  input  NUM_REQ*CNT_W  blink count for source i, located at bits [i*CNT_W +: CNT_W]. A value of 0 means continuous blinking.
- grant  output  NUM_REQ  one-hot; identifies the source being served.
- done  output  NUM_REQ  one-cycle pulse on the served source's bit when its burst completes.
- led_out  output  1  LED drive.
- busy  output  1  high in the BLINK and GAP states.

## Operation
- Reset values: state=IDLE, grant=0, done=0, led_out=0, busy=0. Internal counters are cleared.
- IDLE:
  - led_out=0.
  - If req is nonzero, the lowest set index wins.
  - grant is set to that one-hot index.
  - The remaining count is loaded from req_count[winner], and the block goes to BLINK.
  - A tick in IDLE is ignored.
- BLINK:
  - Each tick toggles led_out. The first tick after entry drives it 0→1.
  - Each 1→0 toggle completes one blink and decrements the remaining count.
  - Completion occurs at the tick that performs the final 1→0 toggle with remaining=1. At that tick:
    - led_out←0.
    - done←grant for exactly one cycle.
    - grant←0.
    - If GAP_TICKS>0, the gap counter←GAP_TICKS and the state goes to GAP. Otherwise the state goes to IDLE.
  - Continuous mode (count 0) never completes.
  - Abort: if req[served] is low in any BLINK cycle:
    - Next cycle: led_out=0, grant=0, done is not pulsed.
    - The block enters GAP, or IDLE if GAP_TICKS=0.
    - Abort takes precedence over a coincident tick.
  - Non-preemptive: a higher-priority request arriving mid-burst waits.
  - Changes to req_count after the count is latched are ignored.
- GAP:
  - led_out=0, grant=0.
  - Each tick decrements the gap counter.
  - The tick that brings it to 0 moves the state to IDLE.
  - Requests are not examined in GAP.
- The counter is CNT_W bits. The maximum burst is 2^CNT_W−1 blinks; no wrap occurs because a count of 0 is decoded as continuous mode before any decrement.
- Reset asserted mid-operation forces all outputs to their reset values immediately (asynchronous). The interrupted burst is lost without a done pulse.

## Timing
- Request to grant: req is sampled high in IDLE at edge k, and grant is high after edge k. If req and tick are both high in that cycle, the tick is not used.
- First LED rise: the first tick sampled with state=BLINK sets led_out=1 after that edge. The minimum latency from req is 2 edges.
- A burst of N blinks consumes exactly 2N ticks in BLINK. done and led_out falling occur on the same edge.
- After done, re-arbitration happens on the GAP_TICKS-th tick. The next grant follows 1 cycle later, in IDLE.
- grant, done, led_out and busy are all registered with no combinational path from inputs.

## Test plan
- Reset and idle: hold rst_n=0 with req=3'b111 and ticks running. Required: grant=0, led_out=0, busy=0. Release reset; grant=3'b001 one cycle after the first req sample.
- Single burst: req[1]=1, count1=3, GAP_TICKS=2, tick every 4 cycles. Required:
  - led_out is high for 3 tick intervals separated by low intervals.
  - done=3'b010 for one cycle on the 6th tick.
  - busy falls on the 2nd tick after that.
- Priority and non-preemption: req[2] is served with count 2. Raise req[0] (count 1) after the first tick. Required:
  - req[2] completes both blinks and receives done[2].
  - After the gap, grant=3'b001.
- Continuous and abort: req[0]=1 with count 0 for 20 ticks, then drop req[0] while led_out=1. Required:
  - led_out toggles on every tick and done never pulses.
  - After the drop: led_out=0 next cycle, grant=0, state GAP.
- Edge cases:
  - GAP_TICKS=0 with back-to-back req[0] at count 1: the next grant appears the cycle after done.
  - A count of 15 produces 15 blinks with no wrap.
  - A req_count change mid-burst has no effect.
- Async reset mid-burst: assert rst_n=0 between clock edges while led_out=1. Required:
  - led_out, grant and busy go to 0 without waiting for a clk edge.
  - No done pulse is generated.
